// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: shared types and funct3 constants for the load/store port.
package lsu_mem_port_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } lsu_state_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_ILLEGAL  = 2'b10,
      FAULT_TIMEOUT  = 2'b11
   } lsu_fault_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
      logic ill;
      if (we) ill = (f3 > F3_W);
      else    ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      return ill;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane enables, store replication, load extraction and access checks.
// Purely combinational; the caller chooses live or latched request fields.
module lsu_align
   import lsu_mem_port_pkg::*;
(
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr_lo,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata,
   output logic        o_misalign,
   output logic        o_illegal
);

   logic       w_ill;
   logic       w_mis;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      w_ill = f3_illegal(i_we, i_funct3);
      w_mis = 1'b0;
      if (!w_ill) begin
         unique case (i_funct3[1:0])
            2'b01:   w_mis = i_addr_lo[0];
            2'b10:   w_mis = |i_addr_lo;
            default: w_mis = 1'b0;
         endcase
      end
   end

   assign o_illegal  = w_ill;
   assign o_misalign = w_mis;

   always_comb begin
      o_be    = 4'b1111;
      o_wdata = i_wdata;
      if (i_we) begin
         unique case (i_funct3[1:0])
            2'b00: begin
               o_be    = 4'b0001 << i_addr_lo;
               o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
               o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
               o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
               o_be    = 4'b1111;
               o_wdata = i_wdata;
            end
         endcase
      end
   end

   always_comb begin
      o_ldata = i_rdata;
      unique case (i_funct3)
         F3_B:    o_ldata = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_ldata = {24'h0, w_byte};
         F3_H:    o_ldata = {{16{w_half[15]}}, w_half};
         F3_HU:   o_ldata = {16'h0, w_half};
         default: o_ldata = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-transaction load/store port for the multicycle core.
// Latches the request, runs one handshaked bus access, returns extended load data.
module lsu_mem_port
   import lsu_mem_port_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              we,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic [1:0]        fault,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic [3:0]        bus_be,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   lsu_state_t        r_state;
   lsu_state_t        w_next;
   lsu_fault_t        r_fault;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic [2:0]        r_funct3;
   logic [1:0]        r_addr_lo;
   logic [ADDR_W-1:0] r_addr;
   logic [3:0]        r_be;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_rdata;

   logic              w_idle;
   logic              w_start;
   logic              w_we;
   logic [2:0]        w_f3;
   logic [1:0]        w_lo;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ldata;
   logic              w_mis;
   logic              w_ill;
   logic              w_last;

   assign w_idle  = (r_state == IDLE);
   assign w_start = w_idle && start;
   assign w_last  = (r_cnt == CNT_LAST);

   // Checks use the live request in IDLE, extraction uses the latched one.
   assign w_we = w_idle ? we          : r_we;
   assign w_f3 = w_idle ? funct3      : r_funct3;
   assign w_lo = w_idle ? addr[1:0]   : r_addr_lo;

   lsu_align u_align (
      .i_we       (w_we),
      .i_funct3   (w_f3),
      .i_addr_lo  (w_lo),
      .i_wdata    (wdata),
      .i_rdata    (bus_rdata),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_ldata    (w_ldata),
      .o_misalign (w_mis),
      .o_illegal  (w_ill)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (start) w_next = (w_mis || w_ill) ? RESP : ACCESS;
         ACCESS:  if (bus_ack || w_last) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fault   <= FAULT_NONE;
         r_cnt     <= '0;
         r_we      <= 1'b0;
         r_funct3  <= 3'b000;
         r_addr_lo <= 2'b00;
         r_addr    <= '0;
         r_be      <= 4'b0000;
         r_wdata   <= '0;
         r_rdata   <= '0;
      end else if (w_start) begin
         r_we      <= we;
         r_funct3  <= funct3;
         r_addr_lo <= addr[1:0];
         r_addr    <= {addr[ADDR_W-1:2], 2'b00};
         r_be      <= w_be;
         r_wdata   <= w_wdata;
         r_cnt     <= '0;
         if (w_ill)      r_fault <= FAULT_ILLEGAL;
         else if (w_mis) r_fault <= FAULT_MISALIGN;
         else            r_fault <= FAULT_NONE;
      end else if (r_state == ACCESS) begin
         if (bus_ack) begin
            if (!r_we) r_rdata <= w_ldata;
            r_fault <= FAULT_NONE;
         end else if (w_last) begin
            r_fault <= FAULT_TIMEOUT;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Request and status decode straight from state so reset drops them at once.
   assign bus_req   = (r_state == ACCESS);
   assign busy      = (r_state == ACCESS);
   assign done      = (r_state == RESP);
   assign fault     = r_fault;
   assign rdata     = r_rdata;
   assign bus_we    = r_we;
   assign bus_addr  = r_addr;
   assign bus_wdata = r_wdata;
   assign bus_be    = r_be;

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: vector table, random model comparison and corner sequences.
module tb_lsu_mem_port;

   localparam int TMO = 8;

   logic        clk;
   logic        rst;
   logic        start;
   logic        we;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic [1:0]  fault;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   int checks;
   int failures;

   lsu_mem_port #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (TMO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .we        (we),
      .funct3    (funct3),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .busy      (busy),
      .done      (done),
      .fault     (fault),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_be    (bus_be),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          wt;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [31:0] erd;
      logic [1:0]  efault;
      int          ereq;
      int          elat;
   } vec_t;

   // Observations from the last transaction
   int          o_req;
   int          o_lat;
   logic [31:0] o_addr;
   logic [3:0]  o_be;
   logic [31:0] o_wd;
   logic        o_we;
   logic [1:0]  o_fault;
   logic [31:0] o_rdata;
   logic        o_done2;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // wt = ACCESS cycles before ack; negative means never ack
   task automatic run_txn(input logic t_we, input logic [2:0] t_f3,
                          input logic [31:0] t_addr, input logic [31:0] t_wd,
                          input logic [31:0] t_rd, input int t_wt);
      @(negedge clk);
      we = t_we; funct3 = t_f3; addr = t_addr; wdata = t_wd;
      start = 1'b1;
      o_req = 0; o_lat = 0;
      o_addr = 'x; o_be = 'x; o_wd = 'x; o_we = 1'bx;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            o_lat = c; o_fault = fault; o_rdata = rdata;
            bus_ack = 1'b0;
            break;
         end
         if (bus_req) begin
            o_req++;
            if (o_req == 1) begin
               o_addr = bus_addr; o_be = bus_be;
               o_wd = bus_wdata; o_we = bus_we;
            end
            bus_ack = (t_wt >= 0) && (o_req == t_wt + 1);
            bus_rdata = bus_ack ? t_rd : $urandom;
         end else begin
            bus_ack = 1'b0;
         end
         @(negedge clk);
      end
      bus_ack = 1'b0;
      @(negedge clk);
      o_done2 = done;
   endtask

   task automatic check_txn(input string nm, input vec_t v);
      chk({nm, " latency"}, o_lat, v.elat);
      chk({nm, " req_cycles"}, o_req, v.ereq);
      chk({nm, " fault"}, {30'h0, o_fault}, {30'h0, v.efault});
      chk({nm, " rdata"}, o_rdata, v.erd);
      chk({nm, " done_width"}, {31'h0, o_done2}, 32'h0);
      if (v.ereq > 0) begin
         chk({nm, " bus_addr"}, o_addr, v.addr & 32'hFFFF_FFFC);
         chk({nm, " bus_be"}, {28'h0, o_be}, {28'h0, v.ebe});
         chk({nm, " bus_we"}, {31'h0, o_we}, {31'h0, v.we});
         if (v.we) chk({nm, " bus_wdata"}, o_wd, v.ewd);
      end
   endtask

   // Reference model from the access rules, using sizes and byte arithmetic
   task automatic model(input logic mwe, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int wt,
                        output logic [1:0] mf, output logic [3:0] mbe,
                        output logic [31:0] mwd, output logic [31:0] mld,
                        output int mreq, output int mlat);
      int sz;
      int off;
      logic ill;
      logic [31:0] v;
      logic [31:0] mask;
      sz  = 1 << f3[1:0];
      off = int'(a % 4);
      ill = mwe ? (f3 >= 3) : (f3 == 3 || f3 >= 6);
      if (ill)                  mf = 2'd2;
      else if (a % sz != 0)     mf = 2'd1;
      else if (wt < 0 || wt >= TMO) mf = 2'd3;
      else                      mf = 2'd0;
      mbe = mwe ? 4'(((1 << sz) - 1) << off) : 4'hF;
      for (int i = 0; i < 4; i++) mwd[8*i +: 8] = wd[8*(i % sz) +: 8];
      mask = (sz >= 4) ? 32'hFFFF_FFFF : 32'((1 << (8*sz)) - 1);
      v = (rd >> (8*off)) & mask;
      if (f3 < 4 && sz < 4 && v[8*sz-1]) v = v | ~mask;
      mld = v;
      if (mf == 2'd1 || mf == 2'd2) begin
         mreq = 0; mlat = 1;
      end else if (mf == 2'd3) begin
         mreq = TMO; mlat = TMO + 1;
      end else begin
         mreq = wt + 1; mlat = wt + 2;
      end
   endtask

   vec_t        tbl[12];
   vec_t        rv;
   logic [31:0] exp_rd;
   logic [31:0] ld;

   initial begin
      checks = 0; failures = 0;
      rst = 1'b1; start = 1'b0; we = 1'b0; funct3 = 3'b000;
      addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;

      //        we  f3    addr        wd            rd            wt  be    ewd           erd           flt ereq elat
      tbl[0]  = '{1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0,        2, 4'hF, 32'hDEADBEEF, 32'h00000000, 2'd0, 3, 4};
      tbl[1]  = '{1'b0, 3'd0, 32'h203, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0,        32'hFFFFFF80, 2'd0, 1, 2};
      tbl[2]  = '{1'b0, 3'd4, 32'h203, 32'h0,        32'h80FF1234, 0, 4'hF, 32'h0,        32'h00000080, 2'd0, 1, 2};
      tbl[3]  = '{1'b1, 3'd1, 32'h102, 32'h0000ABCD, 32'h0,        1, 4'hC, 32'hABCDABCD, 32'h00000080, 2'd0, 2, 3};
      tbl[4]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80010000, 0, 4'hF, 32'h0,        32'hFFFF8001, 2'd0, 1, 2};
      tbl[5]  = '{1'b0, 3'd2, 32'h101, 32'h0,        32'h11111111, 0, 4'hF, 32'h0,        32'hFFFF8001, 2'd1, 0, 1};
      tbl[6]  = '{1'b0, 3'd3, 32'h100, 32'h0,        32'h22222222, 0, 4'hF, 32'h0,        32'hFFFF8001, 2'd2, 0, 1};
      tbl[7]  = '{1'b1, 3'd2, 32'h010, 32'h55AA55AA, 32'h0,       -1, 4'hF, 32'h55AA55AA, 32'hFFFF8001, 2'd3, 8, 9};
      tbl[8]  = '{1'b0, 3'd2, 32'h300, 32'h0,        32'h12345678, 0, 4'hF, 32'h0,        32'h12345678, 2'd0, 1, 2};
      tbl[9]  = '{1'b1, 3'd0, 32'h101, 32'h000000A5, 32'h0,        0, 4'h2, 32'hA5A5A5A5, 32'h12345678, 2'd0, 1, 2};
      tbl[10] = '{1'b0, 3'd5, 32'h202, 32'h0,        32'h80010000, 3, 4'hF, 32'h0,        32'h00008001, 2'd0, 4, 5};
      tbl[11] = '{1'b1, 3'd4, 32'h103, 32'h0,        32'h0,        0, 4'hF, 32'h0,        32'h00008001, 2'd2, 0, 1};

      repeat (2) @(negedge clk);
      chk("reset bus_req", {31'h0, bus_req}, 32'h0);
      chk("reset busy", {31'h0, busy}, 32'h0);
      chk("reset done", {31'h0, done}, 32'h0);
      chk("reset fault", {30'h0, fault}, 32'h0);
      chk("reset rdata", rdata, 32'h0);
      chk("reset bus_be", {28'h0, bus_be}, 32'h0);
      chk("reset bus_addr", bus_addr, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
                 tbl[i].rd, tbl[i].wt);
         check_txn($sformatf("vec%0d", i), tbl[i]);
      end
      exp_rd = 32'h00008001;

      for (int n = 0; n < 40; n++) begin
         rv.we   = $urandom_range(0, 1);
         rv.f3   = 3'($urandom_range(0, 7));
         rv.addr = $urandom;
         rv.wd   = $urandom;
         rv.rd   = $urandom;
         rv.wt   = $urandom_range(0, 9);
         model(rv.we, rv.f3, rv.addr, rv.wd, rv.rd, rv.wt,
               rv.efault, rv.ebe, rv.ewd, ld, rv.ereq, rv.elat);
         if (rv.efault == 2'd0 && !rv.we) exp_rd = ld;
         rv.erd = exp_rd;
         run_txn(rv.we, rv.f3, rv.addr, rv.wd, rv.rd, rv.wt);
         check_txn($sformatf("rnd%0d", n), rv);
      end

      // Reset in the middle of an access: request and busy drop without a clock
      @(negedge clk);
      we = 1'b0; funct3 = 3'd2; addr = 32'h400; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("midrst req_before", {31'h0, bus_req}, 32'h1);
      #2 rst = 1'b1;
      #1;
      chk("midrst req_async", {31'h0, bus_req}, 32'h0);
      chk("midrst busy_async", {31'h0, busy}, 32'h0);
      o_lat = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) o_lat++;
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done || bus_req) o_lat++;
      end
      chk("midrst no_done", o_lat, 32'h0);
      chk("midrst rdata", rdata, 32'h0);

      // Start pulsed during ACCESS is ignored; stray ack in IDLE is ignored
      @(negedge clk);
      we = 1'b0; funct3 = 3'd2; addr = 32'h400; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      o_req = 0; o_lat = 0;
      for (int c = 1; c <= 20; c++) begin
         if (done) begin
            o_lat = c;
            bus_ack = 1'b0;
            break;
         end
         start = (c == 1);
         addr  = (c == 1) ? 32'h500 : 32'h400;
         if (bus_req) begin
            o_req++;
            if (o_req == 2) o_addr = bus_addr;
            bus_ack = (o_req == 4);
            bus_rdata = bus_ack ? 32'hCAFEF00D : 32'h0BADBAD0;
         end else begin
            bus_ack = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_start latency", o_lat, 32'd5);
      chk("busy_start req_cycles", o_req, 32'd4);
      chk("busy_start bus_addr", o_addr, 32'h400);
      chk("busy_start rdata", rdata, 32'hCAFEF00D);
      o_req = 0;
      bus_rdata = 32'h77777777;
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (bus_req || done) o_req++;
         @(negedge clk);
      end
      chk("idle_ack ignored", o_req, 32'h0);
      chk("idle_ack rdata", rdata, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
